linebuf_ctrl_nxn: RTL and testbench

Parametrised line-buffer controller for an N×N sliding-window stage (Census, SAD, Gaussian) in the disparity-map pipeline. It sits between the pixel stream and N-1 single-port-per-side row SRAMs, one SRAM per buffered row. The SRAMs rotate as a circular row buffer, so a new line is written into the bank holding the oldest row. The block emits SRAM addresses, active-low enables, a bank-rotation index for the window mux, and a window-valid flag aligned with SRAM read data.

---
 rtl/linebuf_pkg.sv | 16 +
 rtl/linebuf_col_cnt.sv | 44 ++++
 rtl/linebuf_ctrl_nxn.sv | 181 ++++++++++++++++++
 tb/tb_linebuf_ctrl_nxn.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and helpers for the N x N line-buffer controller.
package linebuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } lb_state_e;

  localparam int LB_RD_LAT = 1;

  function automatic int bank_w(input int win);
    return $clog2(win - 1);
  endfunction

endpackage

// File: rtl/linebuf_col_cnt.sv
// Column counter: wraps at w_eff-1; a restart forces the current pixel to column 0.
module linebuf_col_cnt #(
  parameter int AWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [AWIDTH-1:0] w_eff,
  output logic [AWIDTH-1:0] col,
  output logic              wrap
);

  localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

  logic [AWIDTH-1:0] col_q;
  logic [AWIDTH-1:0] col_d;

  // effective column of the current pixel and next-column computation
  always_comb begin
    col   = restart ? {AWIDTH{1'b0}} : col_q;
    wrap  = en && (col == (w_eff - ONE));
    col_d = col_q;
    if (en) begin
      if (wrap) begin
        col_d = {AWIDTH{1'b0}};
      end else begin
        col_d = col + ONE;
      end
    end else begin
      col_d = col_q;
    end
  end

  // column register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= {AWIDTH{1'b0}};
    end else begin
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/linebuf_ctrl_nxn.sv
// Line-buffer controller for an N x N window over WIN-1 rotating row SRAMs.
// Optional frame-height tracking (height input, eof output) under LINEBUF_HEIGHT_EN.
module linebuf_ctrl_nxn
  import linebuf_pkg::*;
#(
  parameter int WIN    = 5,
  parameter int AWIDTH = 11,
  parameter int BW     = bank_w(WIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              sof,
  input  logic [AWIDTH-1:0] width,
`ifdef LINEBUF_HEIGHT_EN
  input  logic [AWIDTH-1:0] height,
  output logic              eof,
`endif
  output logic [AWIDTH-1:0] wr_addr,
  output logic [AWIDTH-1:0] rd_addr,
  output logic [WIN-2:0]    wr_en_n,
  output logic              rd_en_n,
  output logic [BW-1:0]     wr_bank,
  output logic [BW-1:0]     tap_bank,
  output logic              win_valid,
  output logic              eol,
  output logic              rows_full
);

  localparam int RW = $clog2(WIN);
  localparam logic [RW-1:0]     ROWS           = RW'(WIN - 1);
  localparam logic [RW-1:0]     ROWS_M1        = RW'(WIN - 2);
  localparam logic [RW-1:0]     RC_ONE         = RW'(1);
  localparam logic [BW-1:0]     LAST_BANK      = BW'(WIN - 2);
  localparam logic [BW-1:0]     BANK_ONE       = BW'(1);
  localparam logic [AWIDTH-1:0] FIRST_FULL_COL = AWIDTH'(WIN - 1);

  lb_state_e         state_q, state_d, st_eff;
  logic [AWIDTH-1:0] w_q, w_d, w_eff;
  logic [BW-1:0]     bank_q, bank_d, bank_eff;
  logic [RW-1:0]     row_cnt_q, row_cnt_d, rc_eff;
  logic [BW-1:0]     tap_bank_q, tap_bank_d;
  logic              win_valid_q, win_valid_d;
  logic              eol_q, eol_d;
  logic              sof_acc, acc;
  logic [AWIDTH-1:0] col;
  logic              wrap;

`ifdef LINEBUF_HEIGHT_EN
  localparam logic [AWIDTH-1:0] AONE = AWIDTH'(1);
  logic [AWIDTH-1:0] h_q, h_d, h_eff;
  logic [AWIDTH-1:0] line_q, line_d, line_eff;
  logic              eof_q, eof_d;
`endif

  linebuf_col_cnt #(
    .AWIDTH(AWIDTH)
  ) u_col_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (acc),
    .restart(sof_acc),
    .w_eff  (w_eff),
    .col    (col),
    .wrap   (wrap)
  );

  // FSM next state, bank rotation, enables and next values of the lagged outputs
  always_comb begin
    sof_acc  = clken && sof;
    acc      = clken && (sof || (state_q != IDLE));
    // an accepted sof restarts the frame and this pixel is column 0 of bank 0
    st_eff   = sof_acc ? FILL : state_q;
    w_eff    = sof_acc ? width : w_q;
    bank_eff = sof_acc ? {BW{1'b0}} : bank_q;
    rc_eff   = sof_acc ? {RW{1'b0}} : row_cnt_q;

    w_d         = w_eff;
    state_d     = state_q;
    bank_d      = bank_q;
    row_cnt_d   = row_cnt_q;
    tap_bank_d  = tap_bank_q;
    win_valid_d = 1'b0;
    eol_d       = 1'b0;
    wr_en_n     = {(WIN-1){1'b1}};
`ifdef LINEBUF_HEIGHT_EN
    h_eff    = sof_acc ? height : h_q;
    line_eff = sof_acc ? {AWIDTH{1'b0}} : line_q;
    h_d      = h_eff;
    line_d   = line_q;
    eof_d    = 1'b0;
`endif

    if (acc) begin
      state_d           = st_eff;
      bank_d            = bank_eff;
      row_cnt_d         = rc_eff;
      tap_bank_d        = bank_eff;
      wr_en_n[bank_eff] = 1'b0;
      win_valid_d       = (st_eff == RUN) && (col >= FIRST_FULL_COL);
      eol_d             = wrap;
`ifdef LINEBUF_HEIGHT_EN
      line_d = line_eff;
`endif
      if (wrap) begin
        bank_d = (bank_eff == LAST_BANK) ? {BW{1'b0}} : (bank_eff + BANK_ONE);
        if (rc_eff != ROWS) begin
          row_cnt_d = rc_eff + RC_ONE;
        end else begin
          row_cnt_d = rc_eff;
        end
        if ((st_eff == FILL) && (rc_eff == ROWS_M1)) begin
          state_d = RUN;
        end else begin
          state_d = st_eff;
        end
`ifdef LINEBUF_HEIGHT_EN
        line_d = line_eff + AONE;
        if (line_eff == (h_eff - AONE)) begin
          state_d = IDLE;
          eof_d   = 1'b1;
        end else begin
          eof_d   = 1'b0;
        end
`endif
      end else begin
        bank_d = bank_eff;
      end
    end else begin
      state_d = state_q;
    end
  end

  // state, configuration and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      w_q         <= {AWIDTH{1'b0}};
      bank_q      <= {BW{1'b0}};
      row_cnt_q   <= {RW{1'b0}};
      tap_bank_q  <= {BW{1'b0}};
      win_valid_q <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      bank_q      <= bank_d;
      row_cnt_q   <= row_cnt_d;
      tap_bank_q  <= tap_bank_d;
      win_valid_q <= win_valid_d;
      eol_q       <= eol_d;
    end
  end

`ifdef LINEBUF_HEIGHT_EN
  // frame-height registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q    <= {AWIDTH{1'b0}};
      line_q <= {AWIDTH{1'b0}};
      eof_q  <= 1'b0;
    end else begin
      h_q    <= h_d;
      line_q <= line_d;
      eof_q  <= eof_d;
    end
  end

  assign eof = eof_q;
`endif

  assign wr_addr   = col;
  assign rd_addr   = col;
  assign rd_en_n   = ~acc;
  assign wr_bank   = bank_eff;
  assign tap_bank  = tap_bank_q;
  assign win_valid = win_valid_q;
  assign eol       = eol_q;
  assign rows_full = (row_cnt_q == ROWS);

endmodule

// File: tb/tb_linebuf_ctrl_nxn.sv
// Self-checking bench for linebuf_ctrl_nxn: pixel-index reference model plus literal pins.
module tb_linebuf_ctrl_nxn;
  localparam int WIN = 5;
  localparam int AWIDTH = 11;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst, clken, sof;
  logic [AWIDTH-1:0] width, height;
  logic [AWIDTH-1:0] wr_addr, rd_addr;
  logic [WIN-2:0] wr_en_n;
  logic rd_en_n, win_valid, eol, rows_full, eof;
  logic [BW-1:0] wr_bank, tap_bank;

  linebuf_ctrl_nxn #(.WIN(WIN), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst(rst), .clken(clken), .sof(sof), .width(width),
`ifdef LINEBUF_HEIGHT_EN
    .height(height), .eof(eof),
`endif
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_en_n(wr_en_n), .rd_en_n(rd_en_n),
    .wr_bank(wr_bank), .tap_bank(tap_bank), .win_valid(win_valid), .eol(eol),
    .rows_full(rows_full)
  );

`ifndef LINEBUF_HEIGHT_EN
  assign eof = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0, eol_cnt = 0, eof_cnt = 0;
  bit run_chk = 0;

  // reference model: frame described by pixel index since sof
  bit m_active = 0;
  int m_p = 0, m_w = 1, m_h = 1;
  int m_rf = 0, m_tap = 0;
  bit m_last_acc = 0;

  // expectations for the current cycle (comb) and registered outputs
  bit e_chk;
  int e_addr, e_bank, e_rden;
  logic [WIN-2:0] e_wren;
  int r_wv, r_eol, r_tap, r_rf, r_eof;
  int n_wv, n_eol, n_tap, n_rf, n_eof;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (run_chk) begin
      chk("wr_en_n", int'(wr_en_n), int'(e_wren));
      chk("rd_en_n", int'(rd_en_n), e_rden);
      if (e_chk) begin
        chk("wr_addr", int'(wr_addr), e_addr);
        chk("rd_addr", int'(rd_addr), e_addr);
        chk("wr_bank", int'(wr_bank), e_bank);
      end
      chk("win_valid", int'(win_valid), r_wv);
      chk("eol", int'(eol), r_eol);
      chk("tap_bank", int'(tap_bank), r_tap);
      chk("rows_full", int'(rows_full), r_rf);
      chk("eof", int'(eof), r_eof);
      if (win_valid) wv_cnt++;
      if (eol) eol_cnt++;
      if (eof) eof_cnt++;
    end
  end

  task automatic drive(input bit c, input bit s, input int wd, input int ht);
    int col, line, bank;
    @(posedge clk); #2;
    clken = c; sof = s; width = AWIDTH'(wd); height = AWIDTH'(ht);
    r_wv = n_wv; r_eol = n_eol; r_tap = n_tap; r_rf = n_rf; r_eof = n_eof;
    m_last_acc = c && (s || m_active);
    if (m_last_acc) begin
      if (s) begin
        m_p = 0; m_w = wd; m_h = ht; m_active = 1;
      end
      col = m_p % m_w;
      line = m_p / m_w;
      bank = line % (WIN - 1);
      e_chk = 1; e_addr = col; e_bank = bank; e_rden = 0;
      e_wren = '1; e_wren[bank] = 1'b0;
      n_wv = (line >= WIN - 1 && col >= WIN - 1) ? 1 : 0;
      n_eol = (col == m_w - 1) ? 1 : 0;
      m_tap = bank; n_tap = bank;
      m_rf = ((m_p + 1) / m_w >= WIN - 1) ? 1 : 0;
      n_rf = m_rf;
      n_eof = 0;
`ifdef LINEBUF_HEIGHT_EN
      if (n_eol == 1 && line == m_h - 1) begin
        n_eof = 1;
        m_active = 0;
      end
`endif
      m_p++;
    end else begin
      e_chk = 0; e_rden = 1; e_wren = '1;
      n_wv = 0; n_eol = 0; n_eof = 0; n_tap = m_tap; n_rf = m_rf;
    end
    @(negedge clk); #1;
  endtask

  task automatic reset_expect();
    m_active = 0; m_rf = 0; m_tap = 0;
    e_chk = 1; e_addr = 0; e_bank = 0; e_rden = 1; e_wren = '1;
    r_wv = 0; r_eol = 0; r_tap = 0; r_rf = 0; r_eof = 0;
    n_wv = 0; n_eol = 0; n_tap = 0; n_rf = 0; n_eof = 0;
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #2;
    rst = 1'b0; clken = 1'b1; sof = 1'b0;
    reset_expect();
    #1;
    chk("async_rst_wr_en_n", int'(wr_en_n), 15);
    chk("async_rst_rows_full", int'(rows_full), 0);
    repeat (hold) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  int seq [6] = '{0, 1, 2, 3, 0, 1};
  int acc_cnt, w_r;

  initial begin
    rst = 1'b0; clken = 1'b0; sof = 1'b0; width = 11'd8; height = 11'd6;
    reset_expect();
    run_chk = 1;
    @(negedge clk); #1;
    chk("reset_tap_bank", int'(tap_bank), 0);
    chk("reset_rd_en_n", int'(rd_en_n), 1);
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk); #1;

    // gapless frame, width 8
    wv_cnt = 0; eol_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, i == 0, 8, 6);
      if (i % 8 == 0) chk("line_bank", int'(wr_bank), seq[i / 8]);
      if (i == 31) chk("rows_full_before", int'(rows_full), 0);
      if (i == 32) chk("rows_full_after", int'(rows_full), 1);
    end
    drive(1'b0, 1'b0, 8, 6);
    chk("gapless_wv_pulses", wv_cnt, 8);
    chk("gapless_eol_pulses", eol_cnt, 6);

    // same stream with random gaps; width wiggles without sof
    drive(1'b1, 1'b1, 8, 6);
    acc_cnt = 1;
    for (int k = 0; k < 1000 && acc_cnt < 48; k++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 20), 6);
      if (m_last_acc) acc_cnt++;
    end
    chk("gap_budget", acc_cnt, 48);
    drive(1'b0, 1'b0, 8, 6);

    // sof injected at line 2 column 3
    for (int i = 0; i < 19; i++) drive(1'b1, i == 0, 8, 6);
    drive(1'b1, 1'b1, 8, 6);
    wv_cnt = 0;
    drive(1'b1, 1'b0, 8, 6);
    chk("restart_bank", int'(tap_bank), 0);
    chk("restart_rows_full", int'(rows_full), 0);
    for (int i = 2; i < 36; i++) drive(1'b1, 1'b0, 8, 6);
    drive(1'b0, 1'b0, 8, 6);
    chk("restart_no_early_wv", wv_cnt, 0);
    drive(1'b1, 1'b0, 8, 6);
    drive(1'b0, 1'b0, 8, 6);
    chk("restart_first_wv", wv_cnt, 1);

    // narrow line: width < WIN
    wv_cnt = 0; eol_cnt = 0;
    for (int i = 0; i < 40; i++) drive(1'b1, i == 0, 4, 20);
    drive(1'b0, 1'b0, 4, 20);
    chk("narrow_wv", wv_cnt, 0);
    chk("narrow_eol", eol_cnt, 10);

    // random width and gaps
    w_r = $urandom_range(5, 12);
    drive(1'b1, 1'b1, w_r, 6);
    acc_cnt = 1;
    for (int k = 0; k < 2000 && acc_cnt < 6 * w_r; k++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, w_r, 6);
      if (m_last_acc) acc_cnt++;
    end
    chk("rand_budget", acc_cnt, 6 * w_r);

    // async reset at line 5 column 6
    for (int i = 0; i < 46; i++) drive(1'b1, i == 0, 8, 6);
    do_reset(2);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8, 6);
    chk("post_rst_ignored", int'(wr_en_n), 15);

`ifdef LINEBUF_HEIGHT_EN
    eof_cnt = 0;
    for (int i = 0; i < 48; i++) drive(1'b1, i == 0, 8, 6);
    drive(1'b1, 1'b0, 8, 6);
    chk("eof_pulse_now", int'(eof), 1);
    chk("eof_idle_enables", int'(rd_en_n), 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8, 6);
    chk("eof_pulses", eof_cnt, 1);
    chk("eof_after_wr_en_n", int'(wr_en_n), 15);
`endif

    run_chk = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
